// File: rtl/vga_pixel_out.sv
// vga_pixel_out: final display stage.
// Generates VGA raster timing, publishes the current pixel coordinate to the
// drawing units, and expands the RGB332 pixel from the object multiplexer into
// 8-bit-per-channel DAC values. Sync and blank are delayed by PIPE_DELAY+1
// clocks so that they line up with the multiplexer's pipelined colour.
module vga_pixel_out #(
    parameter int H_ACTIVE   = 640,
    parameter int H_FP       = 16,
    parameter int H_SYNC     = 96,
    parameter int H_BP       = 48,
    parameter int V_ACTIVE   = 480,
    parameter int V_FP       = 10,
    parameter int V_SYNC     = 2,
    parameter int V_BP       = 33,
    parameter int PIPE_DELAY = 2
) (
    input  logic        clk,
    input  logic        resetN,
    input  logic [7:0]  RGBIn,
    output logic [10:0] pixelX,
    output logic [10:0] pixelY,
    output logic        startOfFrame,
    output logic [7:0]  red,
    output logic [7:0]  green,
    output logic [7:0]  blue,
    output logic        hSync,
    output logic        vSync,
    output logic        blankN
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam logic [10:0] L_H_MAX      = 11'(H_TOTAL - 1);
    localparam logic [10:0] L_V_MAX      = 11'(V_TOTAL - 1);
    localparam logic [10:0] L_H_ACT      = 11'(H_ACTIVE);
    localparam logic [10:0] L_V_ACT      = 11'(V_ACTIVE);
    localparam logic [10:0] L_HS_START   = 11'(H_ACTIVE + H_FP);
    localparam logic [10:0] L_HS_END     = 11'(H_ACTIVE + H_FP + H_SYNC - 1);
    localparam logic [10:0] L_VS_START   = 11'(V_ACTIVE + V_FP);
    localparam logic [10:0] L_VS_END     = 11'(V_ACTIVE + V_FP + V_SYNC - 1);

    // Expand a 3-bit channel to 8 bits by bit replication.
    function automatic logic [7:0] expand3(input logic [2:0] c);
        return {c, c, c[2:1]};
    endfunction

    // Expand a 2-bit channel to 8 bits by bit replication.
    function automatic logic [7:0] expand2(input logic [1:0] c);
        return {c, c, c, c};
    endfunction

    logic [10:0] r_h_count;
    logic [10:0] r_v_count;
    logic [10:0] w_h_next;
    logic [10:0] w_v_next;

    logic w_raw_active;
    logic w_raw_hsync;
    logic w_raw_vsync;

    // Delay lines; the chain vectors prepend the raw flag so index k of the
    // chain is the flag delayed by k clocks, which also works for PIPE_DELAY=0.
    logic [PIPE_DELAY:0]   r_act_pipe;
    logic [PIPE_DELAY:0]   r_hs_pipe;
    logic [PIPE_DELAY:0]   r_vs_pipe;
    logic [PIPE_DELAY+1:0] w_act_chain;
    logic [PIPE_DELAY+1:0] w_hs_chain;
    logic [PIPE_DELAY+1:0] w_vs_chain;

    logic [7:0] r_red;
    logic [7:0] r_green;
    logic [7:0] r_blue;
    logic       r_sof;

    assign w_act_chain = {r_act_pipe, w_raw_active};
    assign w_hs_chain  = {r_hs_pipe, w_raw_hsync};
    assign w_vs_chain  = {r_vs_pipe, w_raw_vsync};

    // Next raster position: horizontal wrap advances the line, and the
    // vertical count wraps only when both counters sit at their maximum.
    always_comb begin
        w_h_next = r_h_count;
        w_v_next = r_v_count;
        if (r_h_count == L_H_MAX) begin
            w_h_next = 11'd0;
            if (r_v_count == L_V_MAX) begin
                w_v_next = 11'd0;
            end else begin
                w_v_next = r_v_count + 11'd1;
            end
        end else begin
            w_h_next = r_h_count + 11'd1;
            w_v_next = r_v_count;
        end
    end

    // Raw (undelayed) visible-area and sync flags for the current coordinate.
    always_comb begin
        w_raw_active = 1'b0;
        w_raw_hsync  = 1'b1;
        w_raw_vsync  = 1'b1;
        if ((r_h_count < L_H_ACT) && (r_v_count < L_V_ACT)) begin
            w_raw_active = 1'b1;
        end else begin
            w_raw_active = 1'b0;
        end
        if ((r_h_count >= L_HS_START) && (r_h_count <= L_HS_END)) begin
            w_raw_hsync = 1'b0;
        end else begin
            w_raw_hsync = 1'b1;
        end
        if ((r_v_count >= L_VS_START) && (r_v_count <= L_VS_END)) begin
            w_raw_vsync = 1'b0;
        end else begin
            w_raw_vsync = 1'b1;
        end
    end

    // Raster counters; restart from (0,0) after reset with no frame recovery.
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            r_h_count <= 11'd0;
            r_v_count <= 11'd0;
        end else begin
            r_h_count <= w_h_next;
            r_v_count <= w_v_next;
        end
    end

    // Sync/blank delay lines, cleared to "inactive, syncs deasserted".
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            r_act_pipe <= {(PIPE_DELAY+1){1'b0}};
            r_hs_pipe  <= {(PIPE_DELAY+1){1'b1}};
            r_vs_pipe  <= {(PIPE_DELAY+1){1'b1}};
        end else begin
            r_act_pipe <= w_act_chain[PIPE_DELAY:0];
            r_hs_pipe  <= w_hs_chain[PIPE_DELAY:0];
            r_vs_pipe  <= w_vs_chain[PIPE_DELAY:0];
        end
    end

    // Colour register: expand RGB332, blanked by the active flag of the pixel
    // whose colour is arriving now (the stage just ahead of blankN).
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            r_red   <= 8'd0;
            r_green <= 8'd0;
            r_blue  <= 8'd0;
        end else if (w_act_chain[PIPE_DELAY]) begin
            r_red   <= expand3(RGBIn[7:5]);
            r_green <= expand3(RGBIn[4:2]);
            r_blue  <= expand2(RGBIn[1:0]);
        end else begin
            r_red   <= 8'd0;
            r_green <= 8'd0;
            r_blue  <= 8'd0;
        end
    end

    // Start-of-frame pulse, decoded from the next position so it coincides
    // with pixelX=0, pixelY=V_ACTIVE.
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            r_sof <= 1'b0;
        end else begin
            r_sof <= (w_h_next == 11'd0) && (w_v_next == L_V_ACT);
        end
    end

    assign pixelX       = r_h_count;
    assign pixelY       = r_v_count;
    assign startOfFrame = r_sof;
    assign red          = r_red;
    assign green        = r_green;
    assign blue         = r_blue;
    assign hSync        = w_hs_chain[PIPE_DELAY+1];
    assign vSync        = w_vs_chain[PIPE_DELAY+1];
    assign blankN       = w_act_chain[PIPE_DELAY+1];

endmodule
